fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : FSM states (idle, fetch, execute)
//   PC_W, INSTR_W : program-counter and instruction widths
//   RESET_PC_DEF  : default PC value loaded on reset
package fetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from instruction memory,
// holds it in the instruction register while the control unit executes it, then
// advances or redirects the PC. A wait counter flags a sticky timeout when memory
// does not answer; the FSM keeps retrying after the flag is set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   read request / address (address always equals pc)
//   imem_rdata, imem_valid returned word and its valid strobe
//   stall                 hold the current instruction in execute
//   pc_jump, pc_branch    redirect requests; target_adr is the redirect target
//   instruction           instruction register
//   instr_valid           instruction register holds a fetched word (execute state)
//   pc                    program counter
//   fetch_err             sticky timeout flag, cleared only by reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]      TIMEOUT  = 4'd15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               pc_jump,
  input  logic               pc_branch,
  input  logic [PC_W-1:0]    target_adr,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_err
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [3:0]          cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        cnt_d   = '0;
      end
      StFetch: begin
        // A returned word wins over a timeout landing in the same cycle.
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end else if (cnt_inc == TIMEOUT) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StExec: begin
        if (!stall) begin
          state_d = StFetch;
          cnt_d   = '0;
          // Jump has priority over branch, but both redirect to target_adr.
          if (pc_jump || pc_branch) begin
            pc_d = target_adr;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StExec);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset state, sequential fetch, redirects, PC wrap,
// stall hold, timeout/retry, reset mid-fetch and the valid-at-timeout corner.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        pc_jump;
  logic        pc_branch;
  logic [7:0]  target_adr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        fetch_err;

  int total;
  int bad;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .target_adr  (target_adr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    imem_rdata = 16'h0000;
    imem_valid = 1'b0;
    stall      = 1'b0;
    pc_jump    = 1'b0;
    pc_branch  = 1'b0;
    target_adr = 8'h00;

    // Reset state
    #12;
    chk("rst_req",   {15'd0, imem_req},    16'd0);
    chk("rst_ivld",  {15'd0, instr_valid}, 16'd0);
    chk("rst_pc",    {8'd0, pc},           16'h0000);
    chk("rst_instr", instruction,          16'h0000);
    chk("rst_err",   {15'd0, fetch_err},   16'd0);

    // Zero-wait memory returning 0123: addresses 00,01,02, exec every second cycle
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 16'h0123;
    tick();
    chk("f0_req",  {15'd0, imem_req},    16'd1);
    chk("f0_addr", {8'd0, imem_addr},    16'h0000);
    tick();
    chk("e0_ivld", {15'd0, instr_valid}, 16'd1);
    chk("e0_req",  {15'd0, imem_req},    16'd0);
    chk("e0_inst", instruction,          16'h0123);
    tick();
    chk("f1_addr", {8'd0, imem_addr},    16'h0001);
    chk("f1_ivld", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("e1_ivld", {15'd0, instr_valid}, 16'd1);
    tick();
    chk("f2_addr", {8'd0, imem_addr},    16'h0002);

    // Redirect ignored in FETCH: hold off memory one cycle with pc_jump high
    imem_valid = 1'b0;
    pc_jump    = 1'b1;
    target_adr = 8'h77;
    tick();
    chk("rdir_ign", {8'd0, pc}, 16'h0002);
    // Now in EXEC at 02: jump to 10
    imem_valid = 1'b1;
    target_adr = 8'h10;
    tick();
    chk("e2_ivld", {15'd0, instr_valid}, 16'd1);
    tick();
    chk("jmp10", {8'd0, imem_addr}, 16'h0010);
    tick();
    // EXEC at 10 with jump and branch both high -> 40
    pc_branch  = 1'b1;
    target_adr = 8'h40;
    tick();
    chk("jmp40", {8'd0, imem_addr}, 16'h0040);
    // Branch only -> FF
    pc_jump    = 1'b0;
    target_adr = 8'hFF;
    tick();
    tick();
    chk("brFF", {8'd0, imem_addr}, 16'h00FF);
    // No redirect from FF -> wrap to 00
    pc_branch = 1'b0;
    tick();
    tick();
    chk("wrap", {8'd0, imem_addr}, 16'h0000);

    // Stall: capture 5A5A at 00, then stall 3 cycles with a branch pending
    imem_rdata = 16'h5A5A;
    tick();
    chk("st_inst0", instruction, 16'h5A5A);
    stall      = 1'b1;
    pc_branch  = 1'b1;
    target_adr = 8'h20;
    imem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_ivld", {15'd0, instr_valid}, 16'd1);
      chk("st_pc",   {8'd0, pc},           16'h0000);
      chk("st_inst", instruction,          16'h5A5A);
    end
    stall     = 1'b0;
    pc_branch = 1'b0;
    tick();
    chk("st_next", {8'd0, imem_addr}, 16'h0001);
    chk("st_req",  {15'd0, imem_req}, 16'd1);

    // Timeout: memory silent 15 FETCH cycles, answers on cycle 20
    imem_valid = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    chk("to_err14", {15'd0, fetch_err}, 16'd0);
    tick();
    chk("to_err15", {15'd0, fetch_err}, 16'd1);
    chk("to_req15", {15'd0, imem_req},  16'd1);
    for (int i = 16; i <= 19; i++) tick();
    chk("to_req19", {15'd0, imem_req},  16'd1);
    imem_valid = 1'b1;
    imem_rdata = 16'hC0AA;
    tick();
    chk("to_inst", instruction,          16'hC0AA);
    chk("to_ivld", {15'd0, instr_valid}, 16'd1);
    chk("to_errK", {15'd0, fetch_err},   16'd1);

    // Reset mid-FETCH, late valid on the first edge after release
    tick();
    chk("pre_rst_req", {15'd0, imem_req}, 16'd1);
    imem_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("ar_req",  {15'd0, imem_req},  16'd0);
    chk("ar_pc",   {8'd0, pc},         16'h0000);
    chk("ar_err",  {15'd0, fetch_err}, 16'd0);
    chk("ar_inst", instruction,        16'h0000);
    #2;
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    chk("late_inst", instruction,          16'h0000);
    chk("late_ivld", {15'd0, instr_valid}, 16'd0);
    chk("late_req",  {15'd0, imem_req},    16'd1);
    chk("late_pc",   {8'd0, pc},           16'h0000);

    // Valid arrives in the cycle the counter would reach TIMEOUT
    imem_valid = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    imem_valid = 1'b1;
    imem_rdata = 16'h1234;
    tick();
    chk("edge_inst", instruction,          16'h1234);
    chk("edge_ivld", {15'd0, instr_valid}, 16'd1);
    chk("edge_err",  {15'd0, fetch_err},   16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
